// File: rtl/axi_stream_remove_header.sv
// axi_stream_remove_header
//   Strips a per-packet, programmable number of leading bytes (0..DATA_BYTE_WD)
//   from an AXI-Stream packet and repacks the rest so that every output beat
//   except the last carries full keep. Byte 0 of a beat is the MSB byte.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   valid_in/data_in/keep_in/last_in/ready_in      upstream stream
//   valid_out/data_out/keep_out/last_out/ready_out downstream stream (registered)
//   valid_strip/byte_strip_cnt/ready_strip         per-packet strip count
//   valid_hdr/data_hdr            stripped header bytes (AXIS_RM_HDR_CAPTURE_EN only)
//
// Build option
//   AXIS_RM_HDR_CAPTURE_EN : adds valid_hdr/data_hdr header capture outputs.
//
// state  | meaning
// IDLE   | waiting for strip count
// FIRST  | accepting the first beat of the packet, strip S bytes
// STREAM | accepting later beats
// FLUSH  | emitting leftover hold bytes as the last beat

module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
`ifdef AXIS_RM_HDR_CAPTURE_EN
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
`endif
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    ready_strip
);

    localparam int CW = BYTE_CNT_WD + 1;
    localparam int TW = BYTE_CNT_WD + 2;
    localparam logic [CW-1:0] N_C = CW'(DATA_BYTE_WD);
    localparam logic [TW-1:0] N_T = TW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            s_q, s_d;
    logic [DATA_WD-1:0]       hbuf_q, hbuf_d;
    logic [CW-1:0]            hcnt_q, hcnt_d;
    logic [DATA_WD-1:0]       din_m, ein;
    logic [CW-1:0]            k_in, k_eff;
    logic [TW-1:0]            total;
    logic [2*DATA_WD-1:0]     cand;
    logic                     slot, accept;
    logic                     load, ld_last;
    logic [DATA_WD-1:0]       ld_data;
    logic [DATA_BYTE_WD-1:0]  ld_keep;

    // keep mask with the top c bits set
    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [TW-1:0] c);
        logic [DATA_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones >> c);
    endfunction

    assign slot        = !valid_out || ready_out;
    assign ready_in    = !rst && ((state_q == FIRST) || (state_q == STREAM)) && slot;
    assign ready_strip = !rst && (state_q == IDLE);
    assign accept      = valid_in && ready_in;

    // Zero bytes outside keep so they never leak into repacked output.
    always_comb begin
        k_in  = '0;
        din_m = '0;
        for (int j = 0; j < DATA_BYTE_WD; j++) begin
            if (keep_in[j]) begin
                din_m[8*j +: 8] = data_in[8*j +: 8];
                k_in            = k_in + CW'(1);
            end
        end
    end

    // Candidate output: held bytes followed by the effective input bytes.
    // The upper half is the next output beat, the lower half the new remainder.
    always_comb begin
        if (state_q == FIRST) begin
            ein   = din_m << {s_q, 3'b000};
            k_eff = (k_in > s_q) ? (k_in - s_q) : '0;
        end else begin
            ein   = din_m;
            k_eff = k_in;
        end
        cand  = {hbuf_q, {DATA_WD{1'b0}}} | ({ein, {DATA_WD{1'b0}}} >> {hcnt_q, 3'b000});
        total = TW'(hcnt_q) + TW'(k_eff);
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        hbuf_d  = hbuf_q;
        hcnt_d  = hcnt_q;
        load    = 1'b0;
        ld_data = '0;
        ld_keep = '0;
        ld_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_strip && ready_strip) begin
                    s_d     = (byte_strip_cnt > N_C) ? N_C : byte_strip_cnt;
                    hbuf_d  = '0;
                    hcnt_d  = '0;
                    state_d = FIRST;
                end
            end
            FIRST, STREAM: begin
                if (accept) begin
                    state_d = STREAM;
                    if (!last_in) begin
                        if (total >= N_T) begin
                            load    = 1'b1;
                            ld_data = cand[2*DATA_WD-1 -: DATA_WD];
                            ld_keep = '1;
                            hbuf_d  = cand[DATA_WD-1:0];
                            hcnt_d  = CW'(total - N_T);
                        end else begin
                            hbuf_d  = cand[2*DATA_WD-1 -: DATA_WD];
                            hcnt_d  = CW'(total);
                        end
                    end else if (total == '0) begin
                        state_d = IDLE;
                        hbuf_d  = '0;
                        hcnt_d  = '0;
                    end else if (total <= N_T) begin
                        load    = 1'b1;
                        ld_data = cand[2*DATA_WD-1 -: DATA_WD];
                        ld_keep = keep_of(total);
                        ld_last = 1'b1;
                        state_d = IDLE;
                        hbuf_d  = '0;
                        hcnt_d  = '0;
                    end else begin
                        load    = 1'b1;
                        ld_data = cand[2*DATA_WD-1 -: DATA_WD];
                        ld_keep = '1;
                        hbuf_d  = cand[DATA_WD-1:0];
                        hcnt_d  = CW'(total - N_T);
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (slot) begin
                    load    = 1'b1;
                    ld_data = hbuf_q;
                    ld_keep = keep_of(TW'(hcnt_q));
                    ld_last = 1'b1;
                    state_d = IDLE;
                    hbuf_d  = '0;
                    hcnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= '0;
            hbuf_q    <= '0;
            hcnt_q    <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            s_q    <= s_d;
            hbuf_q <= hbuf_d;
            hcnt_q <= hcnt_d;
            if (load) begin
                valid_out <= 1'b1;
                data_out  <= ld_data;
                keep_out  <= ld_keep;
                last_out  <= ld_last;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef AXIS_RM_HDR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_hdr <= 1'b0;
            data_hdr  <= '0;
        end else begin
            valid_hdr <= 1'b0;
            if (accept && (state_q == FIRST)) begin
                valid_hdr <= (s_q != '0);
                data_hdr  <= data_in & ~({DATA_WD{1'b1}} >> {s_q, 3'b000});
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
module tb_axi_stream_remove_header;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [NB-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [NB-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic          valid_strip = 1'b0;
    logic [2:0]    byte_strip_cnt = '0;
    logic          ready_strip;
`ifdef AXIS_RM_HDR_CAPTURE_EN
    logic          valid_hdr;
    logic [DW-1:0] data_hdr;
    int            hdr_pulses = 0;
`endif

    always #5 clk = ~clk;

    axi_stream_remove_header #(.DATA_WD(DW)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_out(ready_out),
`ifdef AXIS_RM_HDR_CAPTURE_EN
        .valid_hdr(valid_hdr), .data_hdr(data_hdr),
`endif
        .valid_strip(valid_strip), .byte_strip_cnt(byte_strip_cnt),
        .ready_strip(ready_strip)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [36:0]   got[$];
    int            got_cyc[$];
    int            acc_cyc[$];
    logic [36:0]   exp_q[$];
    logic [DW-1:0] pd[$];
    logic [NB-1:0] pk[$];

    int   rdy_mode = 0;     // 0: ready_out = rdy_hold, 1: random
    logic rdy_hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        ready_out = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_hold;
    end

    // Handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            got.push_back({data_out, keep_out, last_out});
            got_cyc.push_back(cyc);
        end
        if (!rst && valid_in && ready_in) acc_cyc.push_back(cyc);
`ifdef AXIS_RM_HDR_CAPTURE_EN
        if (!rst && valid_hdr) hdr_pulses++;
`endif
    end

    // Reference: collect surviving bytes of the packet, cut into N-byte beats.
    function automatic void build_exp(input int s);
        logic [7:0]    bq[$];
        logic [DW-1:0] w, d;
        logic [NB-1:0] kk;
        int sc, n;
        sc = (s > NB) ? NB : s;
        exp_q.delete();
        for (int b = 0; b < pd.size(); b++) begin
            w = pd[b];
            for (int i = 0; i < $countones(pk[b]); i++)
                if (!(b == 0 && i < sc)) bq.push_back(w[DW-1-8*i -: 8]);
        end
        while (bq.size() > 0) begin
            n  = (bq.size() > NB) ? NB : bq.size();
            d  = '0;
            for (int i = 0; i < n; i++) d[DW-1-8*i -: 8] = bq.pop_front();
            kk = '1;
            kk = kk << (NB - n);
            exp_q.push_back({d, kk, (bq.size() == 0) ? 1'b1 : 1'b0});
        end
    endfunction

    task automatic send_pkt(input int s, input bit gaps, input bit no_last);
        int t;
        @(posedge clk); #1;
        valid_strip    = 1'b1;
        byte_strip_cnt = 3'(s);
        t = 0;
        @(negedge clk);
        while (!ready_strip && t < 200) begin @(negedge clk); t++; end
        if (!ready_strip) begin
            vectors++; errors++;
            $display("FAIL strip_handshake timeout ready_strip=%0b required 1", ready_strip);
        end
        @(posedge clk); #1;
        valid_strip    = 1'b0;
        byte_strip_cnt = 3'($urandom);
        for (int b = 0; b < pd.size(); b++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            valid_in = 1'b1;
            data_in  = pd[b];
            keep_in  = pk[b];
            last_in  = (b == pd.size() - 1) && !no_last;
            t = 0;
            @(negedge clk);
            while (!ready_in && t < 200) begin @(negedge clk); t++; end
            if (!ready_in) begin
                vectors++; errors++;
                $display("FAIL beat_handshake timeout ready_in=%0b required 1", ready_in);
            end
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = $urandom;
        keep_in  = 4'($urandom);
    endtask

    task automatic drain(input int n);
        int t = 0;
        while (got.size() < n && t < 400) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
    endtask

    task automatic load_plan1();
        pd = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        pk = '{4'hF, 4'hF, 4'hF};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_strip = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({valid_out, data_out, keep_out, last_out} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%0b d=%h k=%h l=%0b required all 0",
                     valid_out, data_out, keep_out, last_out);
        end
        vectors++;
        if ({ready_in, ready_strip} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got ready_in=%0b ready_strip=%0b required 0 0", ready_in, ready_strip);
        end
        @(posedge clk); #1;
        valid_strip = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ready_strip !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready_strip got %0b required 1", ready_strip);
        end
    endtask

    task automatic test_realign();
        logic [36:0] e[3];
        e = '{{32'h22334455, 4'hF, 1'b0}, {32'h66778899, 4'hF, 1'b0}, {32'hAABBCC00, 4'hE, 1'b1}};
        got.delete();
        load_plan1();
        send_pkt(1, 0, 0);
        drain(3);
        vectors++;
        if (got.size() !== 3) begin
            errors++;
            $display("FAIL realign_count got %0d required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== e[i]) begin
                errors++;
                $display("FAIL realign_beat%0d got %h required %h", i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_passthrough();
        got.delete(); got_cyc.delete(); acc_cyc.delete();
`ifdef AXIS_RM_HDR_CAPTURE_EN
        hdr_pulses = 0;
`endif
        pd = '{32'hCAFEF00D, 32'h12340000};
        pk = '{4'hF, 4'hC};
        send_pkt(0, 0, 0);
        drain(2);
        vectors++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL pass_count got %0d required 2", got.size());
        end else begin
            vectors++;
            if (got[0] !== {32'hCAFEF00D, 4'hF, 1'b0} || got[1] !== {32'h12340000, 4'hC, 1'b1}) begin
                errors++;
                $display("FAIL pass_data got %h %h required %h %h", got[0], got[1],
                         {32'hCAFEF00D, 4'hF, 1'b0}, {32'h12340000, 4'hC, 1'b1});
            end
            vectors++;
            if (acc_cyc.size() !== 2 || got_cyc[0] !== acc_cyc[0] + 1 || got_cyc[1] !== got_cyc[0] + 1) begin
                errors++;
                $display("FAIL pass_latency got out_cyc %0d %0d acc_cyc %0d required out = acc+1, back-to-back",
                         got_cyc[0], got_cyc[1], acc_cyc[0]);
            end
        end
`ifdef AXIS_RM_HDR_CAPTURE_EN
        vectors++;
        if (hdr_pulses !== 0) begin
            errors++;
            $display("FAIL hdr_pulse_s0 got %0d required 0", hdr_pulses);
        end
`endif
    endtask

    task automatic test_strip_all();
        got.delete();
`ifdef AXIS_RM_HDR_CAPTURE_EN
        hdr_pulses = 0;
`endif
        pd = '{32'hDEADBEEF, 32'h01020304};
        pk = '{4'hF, 4'hC};
        send_pkt(4, 0, 0);
        drain(1);
        vectors++;
        if (got.size() !== 1 || got[0] !== {32'h01020000, 4'hC, 1'b1}) begin
            errors++;
            $display("FAIL strip_all got n=%0d beat=%h required n=1 beat=%h",
                     got.size(), (got.size() > 0) ? got[0] : 37'd0, {32'h01020000, 4'hC, 1'b1});
        end
`ifdef AXIS_RM_HDR_CAPTURE_EN
        vectors++;
        if (hdr_pulses !== 1 || data_hdr !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL hdr_capture got pulses=%0d data=%h required 1 DEADBEEF", hdr_pulses, data_hdr);
        end
`endif
    endtask

    task automatic test_flush();
        got.delete();
        pd = '{32'hA0A1A2A3, 32'hB0B1B2B3};
        pk = '{4'hF, 4'hF};
        send_pkt(1, 0, 0);
        @(negedge clk);
        vectors++;
        if (ready_in !== 1'b0 || ready_strip !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got ready_in=%0b ready_strip=%0b required 0 0", ready_in, ready_strip);
        end
        drain(2);
        vectors++;
        if (got.size() !== 2 || got[0] !== {32'hA1A2A3B0, 4'hF, 1'b0} || got[1] !== {32'hB1B2B300, 4'hE, 1'b1}) begin
            errors++;
            $display("FAIL flush_beats got n=%0d %h %h required %h %h", got.size(),
                     (got.size() > 0) ? got[0] : 37'd0, (got.size() > 1) ? got[1] : 37'd0,
                     {32'hA1A2A3B0, 4'hF, 1'b0}, {32'hB1B2B300, 4'hE, 1'b1});
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] e[3];
        int t;
        e = '{{32'h22334455, 4'hF, 1'b0}, {32'h66778899, 4'hF, 1'b0}, {32'hAABBCC00, 4'hE, 1'b1}};
        got.delete();
        load_plan1();
        rdy_hold = 1'b0;
        fork
            send_pkt(1, 0, 0);
        join_none
        t = 0;
        @(negedge clk);
        while (!valid_out && t < 100) begin @(negedge clk); t++; end
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (valid_out !== 1'b1 || data_out !== 32'h22334455 || ready_in !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got v=%0b d=%h ready_in=%0b required 1 22334455 0",
                         c, valid_out, data_out, ready_in);
            end
            @(negedge clk);
        end
        rdy_hold = 1'b1;
        wait fork;
        drain(3);
        vectors++;
        if (got.size() !== 3) begin
            errors++;
            $display("FAIL bp_count got %0d required 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== e[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h required %h", i, got[i], e[i]);
            end
        end
    endtask

    task automatic test_drop_reset();
        got.delete();
        pd = '{32'h11223300};
        pk = '{4'hE};
        send_pkt(3, 0, 0);
        @(negedge clk);
        vectors++;
        if (ready_strip !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready_strip got %0b required 1", ready_strip);
        end
        drain(0);
        vectors++;
        if (got.size() !== 0) begin
            errors++;
            $display("FAIL drop_no_output got %0d beats required 0", got.size());
        end
        load_plan1();
        pd.pop_back(); pk.pop_back();
        send_pkt(1, 0, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({valid_out, data_out, keep_out, last_out, ready_in, ready_strip} !== 40'd0) begin
            errors++;
            $display("FAIL midpkt_reset got v=%0b d=%h k=%h l=%0b ri=%0b rs=%0b required all 0",
                     valid_out, data_out, keep_out, last_out, ready_in, ready_strip);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        load_plan1();
        send_pkt(1, 0, 0);
        drain(3);
        vectors++;
        if (got.size() !== 3 || got[0] !== {32'h22334455, 4'hF, 1'b0} ||
            got[1] !== {32'h66778899, 4'hF, 1'b0} || got[2] !== {32'hAABBCC00, 4'hE, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_pkt got n=%0d first=%h required 3 beats starting 22334455",
                     got.size(), (got.size() > 0) ? got[0] : 37'd0);
        end
    endtask

    task automatic test_random();
        int s, nb, kl;
        logic [NB-1:0] kk;
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            s  = $urandom_range(0, 7);
            nb = $urandom_range(1, 5);
            pd.delete(); pk.delete();
            for (int b = 0; b < nb; b++) begin
                pd.push_back($urandom);
                if (b == nb - 1) begin
                    kl = $urandom_range(1, NB);
                    kk = '1;
                    kk = kk << (NB - kl);
                    pk.push_back(kk);
                end else begin
                    pk.push_back('1);
                end
            end
            build_exp(s);
            got.delete();
            send_pkt(s, 1, 0);
            drain(exp_q.size());
            vectors++;
            if (got.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand_pkt%0d_count S=%0d got %0d required %0d", p, s, got.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                vectors++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_pkt%0d_beat%0d S=%0d got %h required %h", p, i, s, got[i], exp_q[i]);
                end
            end
        end
        rdy_mode = 0;
        rdy_hold = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_realign();
        test_passthrough();
        test_strip_all();
        test_flush();
        test_backpressure();
        test_drop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
